// File: rtl/matrix_operand_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_operand_loader_if
//
// Bundles the two handshakes of the matrix operand loader:
//   stream side  : in_valid / in_data / in_ready (one element or scalar per beat)
//   operand side : operand_valid / operand_ack with the packed A_flat and scalar
//
// Modports:
//   slave  - the loader (consumes the stream, produces the operand)
//   master - the environment (produces the stream, consumes the operand)
// -----------------------------------------------------------------------------
interface matrix_operand_loader_if #(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
);
  logic                              in_valid;
  logic [ELEM_W-1:0]                 in_data;
  logic                              in_ready;
  logic                              operand_valid;
  logic                              operand_ack;
  logic [DIM_MAX*DIM_MAX*ELEM_W-1:0] A_flat;
  logic [ELEM_W-1:0]                 scalar;

  modport slave (
    input  in_valid, in_data, operand_ack,
    output in_ready, operand_valid, A_flat, scalar
  );

  modport master (
    output in_valid, in_data, operand_ack,
    input  in_ready, operand_valid, A_flat, scalar
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// -----------------------------------------------------------------------------
// matrix_operand_loader
//
// Upstream stage of the scalar/matrix ALU. Collects an NxN matrix (N = 2..5,
// row-major, one raw ELEM_W-bit element per beat) and an optional trailing
// scalar from a valid/ready stream, packs the matrix zero-padded into a
// DIM_MAX x DIM_MAX grid (element (r,c) at index r*DIM_MAX+c) and holds the
// operand under a valid/ack handshake until the ALU consumes it.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        one-cycle load request, sampled only in IDLE
//   size         matrix dimension N, valid 2..DIM_MAX, sampled with start
//   with_scalar  expect one scalar beat after the matrix, sampled with start
//   bus          stream + operand handshake (slave modport)
//   busy         high in any state other than IDLE
//   err          one-cycle pulse on a bad size (or on a stream timeout)
//
// Build option:
//   LOADER_TIMEOUT_EN  when defined, a load aborts after 255 consecutive
//                      cycles without a stream beat.
// -----------------------------------------------------------------------------
module matrix_operand_loader #(
  parameter int ELEM_W  = 8,
  parameter int DIM_MAX = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [2:0]                    size,
  input  logic                          with_scalar,
  matrix_operand_loader_if.slave        bus,
  output logic                          busy,
  output logic                          err
);

  localparam int NUM_ELEM = DIM_MAX * DIM_MAX;
  localparam int IDX_W    = $clog2(NUM_ELEM);
  localparam logic [2:0] DIM_MAX_S = 3'(DIM_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_S,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [ELEM_W-1:0] elem_q [NUM_ELEM];
  logic [ELEM_W-1:0] scalar_q;
  logic [2:0]        row_q, col_q;
  logic [2:0]        n_q;
  logic              ws_q;
  logic              err_q;

  logic [2:0]        n_last;
  logic [IDX_W-1:0]  wr_idx;
  logic              size_ok;

  // Decoded per-cycle events shared by FSM and datapath.
  logic start_ok, start_bad, beat_acc, timeout_hit;
  logic in_ready_c, operand_valid_c;

  assign n_last  = n_q - 3'd1;
  assign wr_idx  = IDX_W'(row_q) * IDX_W'(DIM_MAX) + IDX_W'(col_q);
  assign size_ok = (size >= 3'd2) && (size <= DIM_MAX_S);

`ifdef LOADER_TIMEOUT_EN
  logic [7:0] idle_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt       = state;
    in_ready_c      = 1'b0;
    operand_valid_c = 1'b0;
    start_ok        = 1'b0;
    start_bad       = 1'b0;
    beat_acc        = 1'b0;
    timeout_hit     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (size_ok) begin
            start_ok  = 1'b1;
            state_nxt = S_LOAD_A;
          end else begin
            start_bad = 1'b1;
          end
        end
      end

      S_LOAD_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          beat_acc = 1'b1;
          if (row_q == n_last && col_q == n_last)
            state_nxt = ws_q ? S_LOAD_S : S_HOLD;
        end
      end

      S_LOAD_S: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          beat_acc  = 1'b1;
          state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        operand_valid_c = 1'b1;
        if (bus.operand_ack) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    // The 255th consecutive empty cycle of a load abandons it.
    if ((state == S_LOAD_A || state == S_LOAD_S) && !bus.in_valid &&
        idle_cnt_q == 8'd254) begin
      timeout_hit = 1'b1;
      state_nxt   = S_IDLE;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Operand datapath
  // ---------------------------------------------------------------------------
  // NOTE: the element store is reset explicitly because A_flat must read zero
  // after reset; it is a register file, not an inferred RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_q   <= '{default: '0};
      scalar_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      n_q      <= '0;
      ws_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= start_bad || timeout_hit;

      if (start_ok) begin
        n_q      <= size;
        ws_q     <= with_scalar;
        elem_q   <= '{default: '0};
        scalar_q <= '0;
        row_q    <= '0;
        col_q    <= '0;
      end else if (timeout_hit) begin
        elem_q   <= '{default: '0};
        scalar_q <= '0;
        row_q    <= '0;
        col_q    <= '0;
      end else if (beat_acc) begin
        if (state == S_LOAD_A) begin
          elem_q[wr_idx] <= bus.in_data;
          if (col_q == n_last) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 3'd1;
          end
        end else begin
          scalar_q <= bus.in_data;
        end
      end
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Counts consecutive empty cycles while a load is in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state == S_LOAD_A || state == S_LOAD_S) && !beat_acc &&
                 !timeout_hit) begin
      idle_cnt_q <= idle_cnt_q + 8'd1;
    end else begin
      idle_cnt_q <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.A_flat = '0;
    for (int i = 0; i < NUM_ELEM; i++)
      bus.A_flat[i*ELEM_W +: ELEM_W] = elem_q[i];
  end

  assign bus.scalar        = scalar_q;
  assign bus.in_ready      = in_ready_c;
  assign bus.operand_valid = operand_valid_c;
  assign busy              = (state != S_IDLE);
  assign err               = err_q;

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream stage of the scalar/matrix ALU.
- Collects matrix elements (row-major, one signed 8-bit element per beat) plus an optional scalar from a valid/ready byte stream.
- Packs them into the 200-bit flat 5x5 operand (element i at bits [i*8 +: 8]) and holds the operand stable under a valid/ack handshake until the ALU side consumes it.
- Smaller matrices (2x2..4x4) are zero-padded into the 5x5 grid.

Parameters:
- ELEM_W, 8, element and scalar width in bits.
- DIM_MAX, 5, maximum matrix dimension; flat width = DIM_MAX*DIM_MAX*ELEM_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- size  input  3  matrix dimension N (valid 2..5); sampled with start.
- with_scalar  input  1  when 1, one extra beat after the matrix is captured as the scalar; sampled with start.
- in_valid  input  1  stream beat valid.
- in_data  input  8  stream beat, signed element or scalar.
- in_ready  output  1  loader accepts a beat this cycle.
- operand_valid  output  1  A_flat/scalar complete and stable.
- operand_ack  input  1  consumer has taken the operand.
- A_flat  output  200  packed 5x5 matrix, element (r,c) at index r*5+c.
- scalar  output  8  captured signed scalar.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle error pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge), effective next cycle, including mid-load:
  - State goes to IDLE.
  - A_flat=0, scalar=0, in_ready=0, operand_valid=0, busy=0, err=0.
  - Row/column counters = 0.
  - Any partial load is discarded.
- FSM states: IDLE, LOAD_A, LOAD_S, HOLD.
- IDLE:
  - in_ready=0.
  - start with 2<=size<=5: latch N and with_scalar; clear A_flat and scalar to 0; go to LOAD_A with row=col=0.
  - start with size<2 or size>5: err=1 for exactly one cycle; remain in IDLE; A_flat unchanged.
- LOAD_A:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready; in_data is written to index row*5+col.
  - col increments; at col==N-1, col wraps to 0 and row increments.
  - Bubbles (in_valid=0) hold all state.
  - The beat at row==N-1, col==N-1 is the last element: go to LOAD_S if with_scalar, else HOLD.
- LOAD_S:
  - in_ready=1.
  - The accepted beat is stored to scalar, then go to HOLD.
- HOLD:
  - in_ready=0, operand_valid=1.
  - A_flat and scalar are stable.
  - operand_ack=1: operand_valid drops next cycle and state returns to IDLE.
  - A_flat/scalar keep their values in IDLE until the next valid start.
- Latency: operand_valid rises on the cycle after the final accepted beat. Minimum total for N=5 with scalar is 1 start cycle + 26 beat cycles, then operand_valid.
- start while busy is ignored (no error).
- operand_ack outside HOLD is ignored.
- in_valid during IDLE/HOLD is not accepted; the stream source must hold its data.
- Padding positions (row>=N or col>=N) always read 0.
- Elements are stored raw; no arithmetic or sign handling in this block.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs in LOAD_A/LOAD_S.
  - It clears on every accepted beat and increments on each cycle with in_valid=0.
  - When it reaches 255, the load aborts: err=1 for one cycle, state goes to IDLE, and A_flat and scalar are cleared to 0. operand_valid is never asserted for that load.
- Not defined:
  - No counter logic.
  - LOAD_A/LOAD_S wait indefinitely for beats.
  - err is driven only by size errors.

Test Plan:
- 5x5 load: start, size=5, with_scalar=1; beats 1..25 then 0xFD -> A_flat byte i = i+1, scalar=0xFD (-3); operand_valid rises the cycle after beat 26; ack returns busy=0 next cycle.
- 3x3 load: size=3, with_scalar=0; beats 0x11..0x19 -> indices 0,1,2,5,6,7,10,11,12 hold 0x11..0x19, all other bytes 0; no scalar beat consumed; scalar=0.
- Bad size: start with size=6, and separately size=1 -> err high exactly one cycle, busy=0, in_ready=0, A_flat unchanged from the previous operand.
- Bubbles and hold: 4x4 load with in_valid toggled every other cycle; in_valid held high in HOLD for 10 cycles before ack -> exactly 16 beats accepted, in_ready=0 throughout HOLD, A_flat constant.
- Reset mid-load: rst_n=0 after 7 beats of a 5x5 load -> next cycle A_flat=0, busy=0, operand_valid=0. A following full 2x2 load of 4,5,6,7 yields bytes 0,1,5,6 = 4,5,6,7.
- With LOADER_TIMEOUT_EN: stop in_valid after 3 beats -> err pulses after 255 idle cycles, state IDLE, A_flat=0, operand_valid never asserted. Without the macro: still busy after 1000 cycles.
